lcd_power_seq: RTL and testbench
================================

LCD_POWER_SEQ -- requirements
Module: lcd_power_seq

Interface
REQ-001 Parameter PLL_RST_CYC, default 1000, number of CLK cycles pll_reset is held before lock polling starts.
REQ-002 Parameter LOCK_TIMEOUT, default 900000, number of CLK cycles allowed for lock (10 ms at 90 MHz).
REQ-003 Parameter SETTLE_FRAMES, default 2, number of vsync rising edges after timing-generator release before DE is enabled.
REQ-004 Parameter BL_DELAY_CYC, default 90000, number of CLK cycles between DE enable and backlight on, and between backlight off and DE disable.
REQ-005 Parameter MAX_RETRY, default 3, number of PLL restart attempts allowed before fault.
REQ-006 CLK  in  1  system clock; one clock only.
REQ-007 nRST  in  1  asynchronous, active-low reset.
REQ-008 en  in  1  panel-on request, synchronous to CLK.
REQ-009 pll_lock  in  1  PLL lock status, asynchronous to CLK.
REQ-010 vsync  in  1  vertical sync from the timing generator, asynchronous to CLK, active high.
REQ-011 pll_reset  out  1  drives the PLL RESET input, active high.
REQ-012 vga_nrst  out  1  active-low reset to the timing generator.
REQ-013 den_en  out  1  gates LCD_DE at top level.
REQ-014 backlight  out  1  backlight enable.
REQ-015 ready  out  1  high only in RUN.
REQ-016 fault  out  1  high only in FAULT.
REQ-017 state  out  3  current state encoding.
REQ-018 retry_cnt  out  2  restart attempts in the current power-up.

Function
REQ-019 pll_lock and vsync SHALL each pass through a 2-FF synchronizer, and vsync SHALL be rising-edge detected on the synchronized value. Total latency from a pin change to a state decision is 3 CLK cycles.
REQ-020 State encoding: OFF=0, PLL_RST=1, LOCK_WAIT=2, SETTLE=3, BL_ON=4, RUN=5, FAULT=6, SHUTDOWN=7.
REQ-021 All outputs SHALL be registered and decoded from the next state, so each output changes in the same cycle the state changes.
REQ-022 Outputs by state:
- OFF and FAULT: pll_reset=1, vga_nrst=0, den_en=0, backlight=0.
- PLL_RST: pll_reset=1; all others 0.
- LOCK_WAIT: all outputs 0.
- SETTLE: vga_nrst=1.
- BL_ON: vga_nrst=1, den_en=1.
- RUN: vga_nrst=1, den_en=1, backlight=1.
- SHUTDOWN: vga_nrst=1, den_en=1, backlight=0.
REQ-023 OFF: en=1 -> PLL_RST, and the cycle counter SHALL be loaded.
REQ-024 PLL_RST: after exactly PLL_RST_CYC cycles in the state -> LOCK_WAIT.
REQ-025 LOCK_WAIT: synchronized lock=1 -> SETTLE.
- When the counter reaches LOCK_TIMEOUT without lock, a retry SHALL be taken.
- Retry: if retry_cnt < MAX_RETRY, increment retry_cnt and go to PLL_RST.
- Otherwise go to FAULT.
REQ-026 SETTLE: on the SETTLE_FRAMES-th vsync rising edge -> BL_ON.
REQ-027 BL_ON: after BL_DELAY_CYC cycles -> RUN, and retry_cnt SHALL be cleared.
REQ-028 In SETTLE, BL_ON or RUN, loss of synchronized lock SHALL take the retry path (REQ-025), and the retry path takes priority over en.
REQ-029 en=0 in PLL_RST, LOCK_WAIT, SETTLE or BL_ON -> OFF immediately.
REQ-030 en=0 in RUN -> SHUTDOWN. SHUTDOWN lasts BL_DELAY_CYC cycles and then goes to OFF; en is ignored during SHUTDOWN.
REQ-031 FAULT is held until en=0, then -> OFF with retry_cnt cleared.
REQ-032 Entering OFF SHALL clear retry_cnt.
REQ-033 A single down-counter SHALL be shared by all timed states and reloaded on every state entry.
- Counter width is $clog2 of the largest timing parameter.
- Frame counter width is $clog2(SETTLE_FRAMES+1).
- Neither counter may wrap.

Reset
REQ-034 On nRST=0, asynchronously: state=OFF, counters=0, retry_cnt=0, synchronizer flops=0, and outputs per OFF (pll_reset=1, all others 0).
REQ-035 Reset asserted mid-operation, including RUN, SHALL force backlight=0 and den_en=0 immediately, with no shutdown delay.

Structure
REQ-036 Package lcd_seq_pkg SHALL hold the state enum and encoding, and the retry_cnt width.
REQ-037 One sub-module, lcd_seq_sync (2-FF synchronizer, async active-low reset), instantiated twice.

Verification (PLL_RST_CYC=4, LOCK_TIMEOUT=20, SETTLE_FRAMES=2, BL_DELAY_CYC=5, MAX_RETRY=2)
REQ-038 Normal bring-up: en=1, lock rises 10 cycles after pll_reset falls, two vsync pulses.
- pll_reset high for exactly 4 cycles.
- den_en rises 3 cycles after the 2nd vsync edge.
- backlight and ready rise 5 cycles later; state=5.
REQ-039 Lock never asserts: retry_cnt steps 1, then 2, then state=6 with fault=1. pll_reset pulses 3 times in total. After en=0, state=0.
REQ-040 Lock drop in RUN for 1 cycle: backlight and den_en fall, retry_cnt=1, and state returns to 1. Re-lock leads back to RUN with retry_cnt=0.
REQ-041 en=0 in RUN: backlight falls next cycle; den_en and vga_nrst fall 5 cycles later; state=0.
REQ-042 nRST pulse in RUN: all outputs reach OFF values asynchronously. After release with en=1, a full bring-up is repeated.
REQ-043 en=0 during SETTLE after 1 vsync edge: state=0; frame count restarts from 0 on the next power-up.

Source files
------------

// File: rtl/lcd_seq_pkg.sv
// Shared types for the LCD power sequencer: state encoding, retry counter width
// and the per-state output decode.
package lcd_seq_pkg;

   typedef enum logic [2:0] {
      ST_OFF       = 3'd0,
      ST_PLL_RST   = 3'd1,
      ST_LOCK_WAIT = 3'd2,
      ST_SETTLE    = 3'd3,
      ST_BL_ON     = 3'd4,
      ST_RUN       = 3'd5,
      ST_FAULT     = 3'd6,
      ST_SHUTDOWN  = 3'd7
   } seq_state_t;

   localparam int unsigned RETRY_W = 2;

   typedef struct packed {
      logic pll_reset;
      logic vga_nrst;
      logic den_en;
      logic backlight;
      logic ready;
      logic fault;
   } seq_out_t;

   function automatic seq_out_t decode_outputs(input seq_state_t s);
      seq_out_t o;
      o = '0;
      case (s)
         ST_OFF, ST_PLL_RST: o.pll_reset = 1'b1;
         ST_FAULT: begin
            o.pll_reset = 1'b1;
            o.fault     = 1'b1;
         end
         ST_SETTLE: o.vga_nrst = 1'b1;
         ST_BL_ON, ST_SHUTDOWN: begin
            o.vga_nrst = 1'b1;
            o.den_en   = 1'b1;
         end
         ST_RUN: begin
            o.vga_nrst  = 1'b1;
            o.den_en    = 1'b1;
            o.backlight = 1'b1;
            o.ready     = 1'b1;
         end
         default: o = '0;
      endcase
      return o;
   endfunction

endpackage

// File: rtl/lcd_power_seq_if.sv
// Panel-side signal bundle of the power sequencer; slave is the sequencer,
// master is whatever drives the request and PLL/timing status.
interface lcd_power_seq_if;
   import lcd_seq_pkg::*;

   logic               en;
   logic               pll_lock;
   logic               vsync;
   logic               pll_reset;
   logic               vga_nrst;
   logic               den_en;
   logic               backlight;
   logic               ready;
   logic               fault;
   logic [2:0]         state;
   logic [RETRY_W-1:0] retry_cnt;

   modport master (
      output en, pll_lock, vsync,
      input  pll_reset, vga_nrst, den_en, backlight, ready, fault, state, retry_cnt
   );

   modport slave (
      input  en, pll_lock, vsync,
      output pll_reset, vga_nrst, den_en, backlight, ready, fault, state, retry_cnt
   );
endinterface

// File: rtl/lcd_seq_sync.sv
// Two-flop synchronizer for a single asynchronous level.
module lcd_seq_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);
   logic meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end
endmodule

// File: rtl/lcd_power_seq.sv
// LCD panel power sequencer: PLL reset/lock, timing-generator release, DE and
// backlight ordering, with bounded PLL retries and a latched fault state.
module lcd_power_seq
   import lcd_seq_pkg::*;
#(
   parameter int unsigned PLL_RST_CYC   = 1000,
   parameter int unsigned LOCK_TIMEOUT  = 900000,
   parameter int unsigned SETTLE_FRAMES = 2,
   parameter int unsigned BL_DELAY_CYC  = 90000,
   parameter int unsigned MAX_RETRY     = 3
) (
   input logic             CLK,
   input logic             nRST,
   lcd_power_seq_if.slave  lcd
);
   localparam int unsigned CNT_MAX =
      (PLL_RST_CYC > LOCK_TIMEOUT) ?
         ((PLL_RST_CYC > BL_DELAY_CYC) ? PLL_RST_CYC : BL_DELAY_CYC) :
         ((LOCK_TIMEOUT > BL_DELAY_CYC) ? LOCK_TIMEOUT : BL_DELAY_CYC);
   localparam int unsigned CNT_W = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam int unsigned FR_W  = $clog2(SETTLE_FRAMES + 1);

   localparam logic [CNT_W-1:0] PLL_LOAD  = CNT_W'(PLL_RST_CYC - 1);
   localparam logic [CNT_W-1:0] LOCK_LOAD = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] BL_LOAD   = CNT_W'(BL_DELAY_CYC - 1);
   localparam logic [FR_W-1:0]  FR_LAST   = FR_W'(SETTLE_FRAMES - 1);

   seq_state_t         st, st_nx;
   logic [CNT_W-1:0]   cnt, cnt_nx;
   logic [FR_W-1:0]    frames, fr_nx;
   logic [RETRY_W-1:0] retry, retry_nx;
   seq_out_t           out_q;
   logic               lock_s, vs_s, vs_prev, vs_rise, retry_path;

   lcd_seq_sync u_lock_sync (.clk(CLK), .rst_n(nRST), .d(lcd.pll_lock), .q(lock_s));
   lcd_seq_sync u_vs_sync   (.clk(CLK), .rst_n(nRST), .d(lcd.vsync),    .q(vs_s));

   assign vs_rise = vs_s & ~vs_prev;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         st      <= ST_OFF;
         cnt     <= '0;
         frames  <= '0;
         retry   <= '0;
         vs_prev <= 1'b0;
         out_q   <= decode_outputs(ST_OFF);
      end else begin
         st      <= st_nx;
         cnt     <= cnt_nx;
         frames  <= fr_nx;
         retry   <= retry_nx;
         vs_prev <= vs_s;
         out_q   <= decode_outputs(st_nx);
      end
   end

   always_comb begin
      st_nx      = st;
      cnt_nx     = cnt;
      fr_nx      = frames;
      retry_nx   = retry;
      retry_path = 1'b0;

      case (st)
         ST_OFF:
            if (lcd.en) st_nx = ST_PLL_RST;
         ST_PLL_RST:
            if (!lcd.en)         st_nx  = ST_OFF;
            else if (cnt == '0)  st_nx  = ST_LOCK_WAIT;
            else                 cnt_nx = cnt - 1'b1;
         ST_LOCK_WAIT:
            if (!lock_s && cnt == '0) retry_path = 1'b1;
            else if (!lcd.en)         st_nx  = ST_OFF;
            else if (lock_s)          st_nx  = ST_SETTLE;
            else                      cnt_nx = cnt - 1'b1;
         ST_SETTLE:
            if (!lock_s)       retry_path = 1'b1;
            else if (!lcd.en)  st_nx = ST_OFF;
            else if (vs_rise) begin
               if (frames == FR_LAST) st_nx = ST_BL_ON;
               else                   fr_nx = frames + 1'b1;
            end
         ST_BL_ON:
            if (!lock_s)         retry_path = 1'b1;
            else if (!lcd.en)    st_nx = ST_OFF;
            else if (cnt == '0) begin
               st_nx    = ST_RUN;
               retry_nx = '0;
            end else             cnt_nx = cnt - 1'b1;
         ST_RUN:
            if (!lock_s)       retry_path = 1'b1;
            else if (!lcd.en)  st_nx = ST_SHUTDOWN;
         ST_SHUTDOWN:
            if (cnt == '0) st_nx  = ST_OFF;
            else           cnt_nx = cnt - 1'b1;
         ST_FAULT:
            if (!lcd.en) st_nx = ST_OFF;
         default: st_nx = ST_OFF;
      endcase

      if (retry_path) begin
         if (32'(retry) < MAX_RETRY) begin
            retry_nx = retry + 1'b1;
            st_nx    = ST_PLL_RST;
         end else begin
            st_nx    = ST_FAULT;
         end
      end

      // One shared timer: every state change reloads it for the state being entered.
      if (st_nx != st) begin
         case (st_nx)
            ST_PLL_RST:            cnt_nx = PLL_LOAD;
            ST_LOCK_WAIT:          cnt_nx = LOCK_LOAD;
            ST_BL_ON, ST_SHUTDOWN: cnt_nx = BL_LOAD;
            default:               cnt_nx = '0;
         endcase
         if (st_nx == ST_SETTLE) fr_nx = '0;
      end
      if (st_nx == ST_OFF) retry_nx = '0;
   end

   assign lcd.pll_reset = out_q.pll_reset;
   assign lcd.vga_nrst  = out_q.vga_nrst;
   assign lcd.den_en    = out_q.den_en;
   assign lcd.backlight = out_q.backlight;
   assign lcd.ready     = out_q.ready;
   assign lcd.fault     = out_q.fault;
   assign lcd.state     = st;
   assign lcd.retry_cnt = retry;
endmodule

// File: tb/tb_lcd_power_seq.sv
// Directed bench for lcd_power_seq with short timing parameters; expected
// cycle counts are worked out by hand from the sequencing rules.
module tb_lcd_power_seq;
   logic CLK = 1'b0;
   logic nRST;
   int unsigned checks = 0;
   int unsigned errors = 0;

   lcd_power_seq_if bus();

   lcd_power_seq #(
      .PLL_RST_CYC  (4),
      .LOCK_TIMEOUT (20),
      .SETTLE_FRAMES(2),
      .BL_DELAY_CYC (5),
      .MAX_RETRY    (2)
   ) dut (
      .CLK (CLK),
      .nRST(nRST),
      .lcd (bus)
   );

   always #5 CLK = ~CLK;

   // Output vector order: {pll_reset, vga_nrst, den_en, backlight, ready, fault}
   function automatic int unsigned outs();
      return 32'({bus.pll_reset, bus.vga_nrst, bus.den_en, bus.backlight, bus.ready, bus.fault});
   endfunction
   function automatic int unsigned st();
      return 32'(bus.state);
   endfunction
   function automatic int unsigned rc();
      return 32'(bus.retry_cnt);
   endfunction

   task automatic check(input string tag, input int unsigned got, input int unsigned exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(negedge CLK);
   endtask

   task automatic wait_state(input string tag, input int unsigned s, input int unsigned budget);
      int unsigned n = 0;
      while (st() != s && n < budget) begin
         step();
         n++;
      end
      check(tag, st(), s);
   endtask

   task automatic vs_pulse();
      bus.vsync = 1'b1;
      repeat (2) step();
      bus.vsync = 1'b0;
      repeat (4) step();
   endtask

   // Full bring-up from OFF with lock and vsync low.
   task automatic power_up();
      int unsigned n;
      bus.en = 1'b1;
      n = 0;
      do begin step(); n++; end while (st() != 2 && n < 50);
      check("pll_rst_cycles", n - 1, 4);
      check("lock_wait_outs", outs(), 'b000000);
      repeat (9) step();
      bus.pll_lock = 1'b1;
      n = 0;
      do begin step(); n++; end while (st() != 3 && n < 50);
      check("lock_to_settle", n, 3);
      check("settle_outs", outs(), 'b010000);
      vs_pulse();
      check("settle_one_frame", st(), 3);
      bus.vsync = 1'b1;
      n = 0;
      do begin step(); n++; end while (!bus.den_en && n < 50);
      bus.vsync = 1'b0;
      check("vsync_to_de", n, 3);
      check("bl_on_state", st(), 4);
      n = 0;
      do begin step(); n++; end while (!bus.backlight && n < 50);
      check("de_to_backlight", n, 5);
      check("run_state", st(), 5);
      check("run_outs", outs(), 'b011110);
      check("run_retry", rc(), 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned n, entries, lw_cyc, pr_cyc, prev;
      int unsigned r_at [3];

      nRST = 1'b0;
      bus.en = 1'b0;
      bus.pll_lock = 1'b0;
      bus.vsync = 1'b0;
      repeat (2) step();
      check("reset_state", st(), 0);
      check("reset_outs", outs(), 'b100000);
      check("reset_retry", rc(), 0);
      nRST = 1'b1;
      step();
      check("idle_off", st(), 0);

      // Normal bring-up
      power_up();

      // One-cycle lock drop in RUN
      bus.pll_lock = 1'b0;
      step();
      bus.pll_lock = 1'b1;
      step();
      check("lockdrop_sync_delay", st(), 5);
      step();
      check("lockdrop_state", st(), 1);
      check("lockdrop_retry", rc(), 1);
      check("lockdrop_outs", outs(), 'b100000);
      wait_state("relock_settle", 3, 20);
      vs_pulse();
      vs_pulse();
      wait_state("relock_run", 5, 20);
      check("relock_retry", rc(), 0);

      // en=0 in RUN; en re-raised mid-shutdown is ignored
      bus.en = 1'b0;
      step();
      check("shutdown_state", st(), 7);
      check("shutdown_outs", outs(), 'b011000);
      bus.en = 1'b1;
      n = 0;
      do begin step(); n++; end while (bus.den_en && n < 50);
      check("shutdown_len", n, 5);
      check("shutdown_to_off", st(), 0);
      check("shutdown_off_outs", outs(), 'b100000);
      bus.en = 1'b0;

      // Asynchronous reset in RUN
      bus.pll_lock = 1'b0;
      repeat (3) step();
      power_up();
      #2;
      nRST = 1'b0;
      #1;
      check("async_rst_outs", outs(), 'b100000);
      check("async_rst_state", st(), 0);
      bus.en = 1'b0;
      bus.pll_lock = 1'b0;
      repeat (2) step();
      nRST = 1'b1;
      power_up();

      // en=0 in SETTLE after one frame; frame count must restart
      bus.en = 1'b0;
      wait_state("t43_off", 0, 20);
      bus.en = 1'b1;
      wait_state("t43_settle", 3, 20);
      vs_pulse();
      bus.en = 1'b0;
      step();
      check("settle_abort_off", st(), 0);
      bus.en = 1'b1;
      wait_state("t43_settle_again", 3, 20);
      vs_pulse();
      check("frame_restart", st(), 3);
      check("frame_restart_outs", outs(), 'b010000);
      vs_pulse();
      check("second_frame_bl_on", st(), 4);
      wait_state("t43_run", 5, 20);

      // Lock never asserts: two retries then FAULT
      bus.en = 1'b0;
      step();
      bus.pll_lock = 1'b0;
      wait_state("t39_off", 0, 20);
      bus.en = 1'b1;
      n = 0; entries = 0; lw_cyc = 0; pr_cyc = 0; prev = st();
      r_at[0] = 99; r_at[1] = 99; r_at[2] = 99;
      while (st() != 6 && n < 200) begin
         step();
         n++;
         if (st() == 1 && prev != 1) begin
            if (entries < 3) r_at[entries] = rc();
            entries++;
         end
         if (st() == 1) pr_cyc++;
         if (st() == 2) lw_cyc++;
         prev = st();
      end
      check("fault_time", n, 73);
      check("pll_rst_entries", entries, 3);
      check("retry_at_entry0", r_at[0], 0);
      check("retry_at_entry1", r_at[1], 1);
      check("retry_at_entry2", r_at[2], 2);
      check("lock_wait_total", lw_cyc, 60);
      check("pll_rst_total", pr_cyc, 12);
      check("fault_outs", outs(), 'b100001);
      check("fault_retry", rc(), 2);
      repeat (3) step();
      check("fault_hold", st(), 6);
      bus.en = 1'b0;
      step();
      check("fault_exit_state", st(), 0);
      check("fault_exit_retry", rc(), 0);
      check("fault_exit_outs", outs(), 'b100000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
